delta_frame_stream: RTL and testbench

Streaming, multi-channel successor to the single-pixel delta stage. Takes base and current grayscale pixels for `CHANNELS` lanes per beat and produces one of three outputs: pass-through, absolute difference, or thresholded binary mask. Also accumulates a per-frame count of changed pixels. It sits between the frame-buffer readback and the blob/centroid logic, with valid/ready flow control on both sides.

---
 rtl/delta_pkg.sv | 13 +
 rtl/delta_frame_lane.sv | 46 ++++
 rtl/delta_frame_stream.sv | 179 +++++++++++++++++
 tb/tb_delta_frame_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/delta_pkg.sv
// rtl/delta_pkg.sv - output mode encoding shared by the delta frame stream
package delta_pkg;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    ABS  = 2'b01,
    MASK = 2'b10,
    RSVD = 2'b11
  } mode_t;

  localparam mode_t MODE_RESET = ABS;

endpackage

// File: rtl/delta_frame_lane.sv
// rtl/delta_frame_lane.sv - one lane: abs diff + threshold compare, and the output mode mux
module delta_frame_lane
  import delta_pkg::*;
#(
  parameter int INPUT_WIDTH = 10
) (
  input  logic [INPUT_WIDTH-1:0] i_curr,
  input  logic [INPUT_WIDTH-1:0] i_base,
  input  logic [INPUT_WIDTH-1:0] i_threshold,
  output logic [INPUT_WIDTH-1:0] o_diff,
  output logic                   o_changed,
  input  logic [1:0]             i_mux_mode,
  input  logic [INPUT_WIDTH-1:0] i_mux_curr,
  input  logic [INPUT_WIDTH-1:0] i_mux_diff,
  input  logic                   i_mux_changed,
  output logic [INPUT_WIDTH-1:0] o_delta,
  output logic                   o_mask
);

  mode_t w_mode;

  // Stage-1 half: subtract the smaller from the larger so the result never wraps.
  always_comb begin
    if (i_curr >= i_base) o_diff = i_curr - i_base;
    else                  o_diff = i_base - i_curr;
  end

  assign o_changed = (o_diff > i_threshold);

  // Stage-2 half works on the registered stage-1 values; RSVD falls through as ABS.
  assign w_mode = mode_t'(i_mux_mode);

  always_comb begin
    o_delta = i_mux_diff;
    o_mask  = i_mux_changed;
    case (w_mode)
      PASS: begin
        o_delta = i_mux_curr;
        o_mask  = 1'b0;
      end
      MASK:    o_delta = i_mux_changed ? '1 : '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/delta_frame_stream.sv
// rtl/delta_frame_stream.sv - two-stage multi-lane delta pipeline with per-frame changed-pixel count
module delta_frame_stream
  import delta_pkg::*;
#(
  parameter int INPUT_WIDTH = 10,
  parameter int CHANNELS    = 1,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                            clk,
  input  logic                            areset,
  input  logic [1:0]                      mode,
  input  logic [INPUT_WIDTH-1:0]          threshold,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sof,
  input  logic                            in_eof,
  input  logic [CHANNELS*INPUT_WIDTH-1:0] base_frame,
  input  logic [CHANNELS*INPUT_WIDTH-1:0] curr_frame,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sof,
  output logic                            out_eof,
  output logic [CHANNELS*INPUT_WIDTH-1:0] delta_frame,
  output logic [CHANNELS-1:0]             motion_mask,
  output logic [COUNT_WIDTH-1:0]          frame_count,
  output logic                            frame_count_valid
);

  localparam int DW = CHANNELS * INPUT_WIDTH;

  logic                   r_rdy_en;
  mode_t                  r_mode;
  logic [INPUT_WIDTH-1:0] r_thr;

  logic                   r1_valid, r1_sof, r1_eof;
  mode_t                  r1_mode;
  logic [DW-1:0]          r1_diff, r1_curr;
  logic [CHANNELS-1:0]    r1_chg;

  logic                   r2_valid, r2_sof, r2_eof;
  logic [DW-1:0]          r2_delta;
  logic [CHANNELS-1:0]    r2_mask;

  logic [COUNT_WIDTH-1:0] r_acc, r_frame_count;
  logic                   r_fcv;

  logic                   w_in_ready, w_in_fire, w_out_fire, w_s1_adv, w_s2_ready;
  mode_t                  w_cfg_mode;
  logic [INPUT_WIDTH-1:0] w_cfg_thr;
  logic [DW-1:0]          w_diff, w_delta;
  logic [CHANNELS-1:0]    w_chg, w_mask;
  logic [COUNT_WIDTH:0]   w_pop, w_sum_ext;
  logic [COUNT_WIDTH-1:0] w_acc_base, w_sum;

  assign w_s2_ready = ~r2_valid | out_ready;
  assign w_s1_adv   = r1_valid & w_s2_ready;
  // r_rdy_en keeps in_ready low through reset and rises on the first edge after release.
  assign w_in_ready = r_rdy_en & (~r1_valid | w_s1_adv);
  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = r2_valid & out_ready;

  // The sof beat itself already uses the freshly presented configuration.
  assign w_cfg_mode = in_sof ? mode_t'(mode) : r_mode;
  assign w_cfg_thr  = in_sof ? threshold : r_thr;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    delta_frame_lane #(
      .INPUT_WIDTH(INPUT_WIDTH)
    ) u_lane (
      .i_curr        (curr_frame[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .i_base        (base_frame[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .i_threshold   (w_cfg_thr),
      .o_diff        (w_diff[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .o_changed     (w_chg[g]),
      .i_mux_mode    (r1_mode),
      .i_mux_curr    (r1_curr[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .i_mux_diff    (r1_diff[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .i_mux_changed (r1_chg[g]),
      .o_delta       (w_delta[g*INPUT_WIDTH +: INPUT_WIDTH]),
      .o_mask        (w_mask[g])
    );
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rdy_en <= 1'b0;
      r_mode   <= MODE_RESET;
      r_thr    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_in_fire && in_sof) begin
        r_mode <= mode_t'(mode);
        r_thr  <= threshold;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r1_valid <= 1'b0;
      r1_sof   <= 1'b0;
      r1_eof   <= 1'b0;
      r1_mode  <= MODE_RESET;
      r1_diff  <= '0;
      r1_curr  <= '0;
      r1_chg   <= '0;
    end else if (w_in_fire) begin
      r1_valid <= 1'b1;
      r1_sof   <= in_sof;
      r1_eof   <= in_eof;
      r1_mode  <= w_cfg_mode;
      r1_diff  <= w_diff;
      r1_curr  <= curr_frame;
      r1_chg   <= w_chg;
    end else if (w_s1_adv) begin
      r1_valid <= 1'b0;
    end
  end

  // Output register holds its contents whenever the downstream stalls.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r2_valid <= 1'b0;
      r2_sof   <= 1'b0;
      r2_eof   <= 1'b0;
      r2_delta <= '0;
      r2_mask  <= '0;
    end else if (w_s1_adv) begin
      r2_valid <= 1'b1;
      r2_sof   <= r1_sof;
      r2_eof   <= r1_eof;
      r2_delta <= w_delta;
      r2_mask  <= w_mask;
    end else if (out_ready) begin
      r2_valid <= 1'b0;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pop = w_pop + {{COUNT_WIDTH{1'b0}}, r2_mask[i]};
    end
  end

  // One spare carry bit detects overflow; the total then pins at all-ones.
  assign w_acc_base = r2_sof ? '0 : r_acc;
  assign w_sum_ext  = {1'b0, w_acc_base} + w_pop;
  assign w_sum      = w_sum_ext[COUNT_WIDTH] ? '1 : w_sum_ext[COUNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_acc         <= '0;
      r_frame_count <= '0;
      r_fcv         <= 1'b0;
    end else begin
      r_fcv <= 1'b0;
      if (w_out_fire) begin
        if (r2_eof) begin
          r_frame_count <= w_sum;
          r_fcv         <= 1'b1;
          r_acc         <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign in_ready          = w_in_ready;
  assign out_valid         = r2_valid;
  assign out_sof           = r2_sof;
  assign out_eof           = r2_eof;
  assign delta_frame       = r2_delta;
  assign motion_mask       = r2_mask;
  assign frame_count       = r_frame_count;
  assign frame_count_valid = r_fcv;

endmodule

// File: tb/tb_delta_frame_stream.sv
// tb/tb_delta_frame_stream.sv - directed and random-backpressure checks for delta_frame_stream
module tb_delta_frame_stream;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic areset;

  logic [1:0]   a_mode;  logic [W-1:0] a_thr;
  logic         a_in_valid, a_in_ready, a_in_sof, a_in_eof;
  logic [W-1:0] a_base, a_curr, a_delta;
  logic         a_out_valid, a_out_ready, a_out_sof, a_out_eof, a_mask, a_fcv;
  logic [19:0]  a_fc;

  logic [1:0]     b_mode;  logic [W-1:0] b_thr;
  logic           b_in_valid, b_in_ready, b_in_sof, b_in_eof;
  logic [4*W-1:0] b_base, b_curr, b_delta;
  logic           b_out_valid, b_out_ready, b_out_sof, b_out_eof, b_fcv;
  logic [3:0]     b_mask, b_fc;

  delta_frame_stream #(.INPUT_WIDTH(W), .CHANNELS(1), .COUNT_WIDTH(20)) dut_a (
    .clk(clk), .areset(areset), .mode(a_mode), .threshold(a_thr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sof(a_in_sof), .in_eof(a_in_eof),
    .base_frame(a_base), .curr_frame(a_curr), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sof(a_out_sof), .out_eof(a_out_eof), .delta_frame(a_delta), .motion_mask(a_mask),
    .frame_count(a_fc), .frame_count_valid(a_fcv));

  delta_frame_stream #(.INPUT_WIDTH(W), .CHANNELS(4), .COUNT_WIDTH(4)) dut_b (
    .clk(clk), .areset(areset), .mode(b_mode), .threshold(b_thr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof), .in_eof(b_in_eof),
    .base_frame(b_base), .curr_frame(b_curr), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sof(b_out_sof), .out_eof(b_out_eof), .delta_frame(b_delta), .motion_mask(b_mask),
    .frame_count(b_fc), .frame_count_valid(b_fcv));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [W:0] ref_lane(input logic [1:0] m, input logic [W-1:0] thr,
                                          input logic [W-1:0] c, input logic [W-1:0] b);
    int d;
    logic ch;
    d  = (int'(c) > int'(b)) ? int'(c) - int'(b) : int'(b) - int'(c);
    ch = (d > int'(thr));
    if (m == 2'b00)      ref_lane = {1'b0, c};
    else if (m == 2'b10) ref_lane = {ch, ch ? 10'h3FF : 10'h000};
    else                 ref_lane = {ch, W'(d)};
  endfunction

  // One beat into dut_a; checks 2-cycle latency and the produced output beat.
  task automatic beat_a(input string tag, input logic [1:0] m, input logic [W-1:0] thr,
                        input logic sof, input logic eof, input logic [W-1:0] c, input logic [W-1:0] b,
                        input logic [W-1:0] want_d, input logic want_m);
    a_mode = m; a_thr = thr; a_in_sof = sof; a_in_eof = eof; a_curr = c; a_base = b;
    a_in_valid = 1'b1;
    #1 check({tag, ".rdy"}, a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_eof = 1'b0;
    check({tag, ".lat"}, a_out_valid, 0);
    @(negedge clk);
    check({tag, ".vld"}, a_out_valid, 1);
    check({tag, ".delta"}, a_delta, want_d);
    check({tag, ".mask"}, a_mask, want_m);
    check({tag, ".flags"}, {a_out_sof, a_out_eof}, {sof, eof});
  endtask

  task automatic beat_b(input string tag, input logic [1:0] m, input logic [W-1:0] thr,
                        input logic sof, input logic eof, input logic [4*W-1:0] c, input logic [4*W-1:0] b,
                        input logic [4*W-1:0] want_d, input logic [3:0] want_m);
    b_mode = m; b_thr = thr; b_in_sof = sof; b_in_eof = eof; b_curr = c; b_base = b;
    b_in_valid = 1'b1;
    #1 check({tag, ".rdy"}, b_in_ready, 1);
    @(negedge clk);
    b_in_valid = 1'b0; b_in_sof = 1'b0; b_in_eof = 1'b0;
    check({tag, ".lat"}, b_out_valid, 0);
    @(negedge clk);
    check({tag, ".vld"}, b_out_valid, 1);
    check({tag, ".delta"}, b_delta, want_d);
    check({tag, ".mask"}, b_mask, want_m);
  endtask

  task automatic frame_done_a(input string tag, input logic [19:0] want);
    @(negedge clk);
    check({tag, ".pulse"}, a_fcv, 1);
    check({tag, ".count"}, a_fc, want);
    @(negedge clk);
    check({tag, ".once"}, a_fcv, 0);
  endtask

  task automatic frame_done_b(input string tag, input logic [3:0] want);
    @(negedge clk);
    check({tag, ".pulse"}, b_fcv, 1);
    check({tag, ".count"}, b_fc, want);
    @(negedge clk);
    check({tag, ".once"}, b_fcv, 0);
  endtask

  logic [12:0] exp_q[$];
  logic [12:0] held, want;
  logic [W:0]  r;
  logic [1:0]  fm;
  logic [W-1:0] fthr;
  logic        prev_stall, acc_prev;
  int          sent, got;

  initial begin
    areset = 1'b1;
    a_mode = 2'b00; a_thr = '0; a_in_valid = 0; a_in_sof = 0; a_in_eof = 0;
    a_base = '0; a_curr = '0; a_out_ready = 1'b1;
    b_mode = 2'b00; b_thr = '0; b_in_valid = 0; b_in_sof = 0; b_in_eof = 0;
    b_base = '0; b_curr = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.a_vld", a_out_valid, 0);
    check("rst.a_rdy", a_in_ready, 0);
    check("rst.a_fc", {a_fcv, a_fc}, 0);
    check("rst.b_out", {b_out_valid, b_delta, b_mask}, 0);
    areset = 1'b0;
    #1 check("rel.rdy_low", a_in_ready, 0);
    @(negedge clk);
    check("rel.a_rdy", a_in_ready, 1);
    check("rel.b_rdy", b_in_ready, 1);

    beat_a("abs0", 2'd1, 10'd0, 1, 0, 10'd700, 10'd200, 10'd500, 1);
    beat_a("abs1", 2'd1, 10'd0, 0, 0, 10'd200, 10'd700, 10'd500, 1);
    beat_a("abs2", 2'd1, 10'd0, 0, 1, 10'd300, 10'd300, 10'd0, 0);
    frame_done_a("abs.fr", 20'd2);

    beat_a("msk0", 2'd2, 10'd50, 1, 0, 10'd150, 10'd100, 10'd0, 0);
    beat_a("msk1", 2'd2, 10'd50, 0, 0, 10'd100, 10'd151, 10'd1023, 1);
    beat_a("msk2", 2'd2, 10'd50, 0, 1, 10'd300, 10'd300, 10'd0, 0);
    frame_done_a("msk.fr", 20'd1);

    beat_a("chg0", 2'd1, 10'd0, 1, 0, 10'd10, 10'd3, 10'd7, 1);
    beat_a("chg1", 2'd0, 10'd100, 0, 0, 10'd20, 10'd5, 10'd15, 1);
    beat_a("chg2", 2'd0, 10'd100, 0, 1, 10'd9, 10'd9, 10'd0, 0);
    frame_done_a("chg.fr", 20'd2);
    beat_a("pass", 2'd0, 10'd100, 1, 1, 10'd20, 10'd5, 10'd20, 0);
    frame_done_a("pass.fr", 20'd0);

    beat_a("rsvd", 2'd3, 10'd0, 1, 1, 10'd5, 10'd9, 10'd4, 1);
    frame_done_a("rsvd.fr", 20'd1);
    beat_a("nosof0", 2'd0, 10'd500, 0, 0, 10'd1, 10'd0, 10'd1, 1);
    beat_a("nosof1", 2'd0, 10'd500, 0, 1, 10'd0, 10'd2, 10'd2, 1);
    frame_done_a("nosof.fr", 20'd2);

    beat_b("q0", 2'd2, 10'd10, 1, 0, {4{10'd20}}, {4{10'd0}}, {4{10'd1023}}, 4'b1111);
    beat_b("q1", 2'd2, 10'd10, 0, 0, {10'd60, 10'd5, 10'd0, 10'd111}, {10'd10, 10'd5, 10'd10, 10'd100},
           {10'd1023, 10'd0, 10'd0, 10'd1023}, 4'b1001);
    beat_b("q2", 2'd2, 10'd10, 0, 1, {10'd11, 10'd20, 10'd0, 10'd5}, {10'd0, 10'd10, 10'd9, 10'd0},
           {10'd1023, 10'd0, 10'd0, 10'd0}, 4'b1000);
    frame_done_b("q.fr", 4'd7);
    beat_b("qz", 2'd2, 10'd10, 1, 1, {4{10'd0}}, {4{10'd0}}, {4{10'd0}}, 4'b0000);
    frame_done_b("qz.fr", 4'd0);
    for (int i = 0; i < 5; i++)
      beat_b($sformatf("sat%0d", i), 2'd2, 10'd10, i == 0, i == 4, {4{10'd100}}, {4{10'd0}},
             {4{10'd1023}}, 4'b1111);
    frame_done_b("sat.fr", 4'd15);

    // Random backpressure stream on dut_a against the bench model.
    sent = 0; got = 0; prev_stall = 0; acc_prev = 0; held = '0; fm = 2'd1; fthr = '0;
    for (int cyc = 0; cyc < 10000 && got < 1000; cyc++) begin
      @(negedge clk);
      if (prev_stall) check("stall.hold", {a_out_sof, a_out_eof, a_mask, a_delta}, held);
      if (acc_prev) a_in_valid = 1'b0;
      a_out_ready = 1'($urandom % 2);
      if (!a_in_valid && sent < 1000 && ($urandom % 4) != 0) begin
        a_in_sof = (sent % 5 == 0);
        a_in_eof = (sent % 5 == 4);
        if (a_in_sof) begin
          fm = 2'($urandom % 4); fthr = W'($urandom % 512);
          a_mode = fm; a_thr = fthr;
        end else begin
          a_mode = 2'($urandom % 4); a_thr = W'($urandom % 1024);
        end
        a_curr = W'($urandom % 1024); a_base = W'($urandom % 1024);
        a_in_valid = 1'b1;
      end
      #1;
      if (a_out_valid && a_out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
        check("rand.out", {a_out_sof, a_out_eof, a_mask, a_delta}, want);
        got++;
      end
      acc_prev = a_in_valid && a_in_ready;
      if (acc_prev) begin
        r = ref_lane(fm, fthr, a_curr, a_base);
        exp_q.push_back({a_in_sof, a_in_eof, r});
        sent++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      held = {a_out_sof, a_out_eof, a_mask, a_delta};
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    check("rand.got", got, 1000);
    check("rand.left", exp_q.size(), 0);

    // Reset in the middle of a frame with an output stalled in stage 2.
    @(negedge clk);
    b_out_ready = 1'b0;
    b_mode = 2'd2; b_thr = 10'd10; b_in_sof = 1; b_in_eof = 0;
    b_curr = {4{10'd100}}; b_base = {4{10'd0}}; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0; b_in_sof = 1'b0;
    @(negedge clk);
    check("mid.held", b_out_valid, 1);
    areset = 1'b1;
    #1;
    check("mid.vld", b_out_valid, 0);
    check("mid.data", {b_delta, b_mask, b_out_sof}, 0);
    check("mid.fc", {b_fcv, b_fc}, 0);
    check("mid.rdy", b_in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0; b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid.nopulse", b_fcv, 0);
    end
    beat_b("post", 2'd2, 10'd10, 0, 1, {4{10'd100}}, {4{10'd0}}, {4{10'd100}}, 4'b1111);
    frame_done_b("post.fr", 4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
